snake_grid_reader: RTL and testbench

Consumer for the packed snake body vector the game FSM produces. On each `write_snake` frame it captures the vector and walks the 8-bit segments, tail first. From these it builds a 16×16 occupancy bitmap, a length count and the head position. A random-access cell query port serves the display path. Publishing is double-buffered, so queries always see a complete frame.

---
 rtl/snake_pkg.sv | 29 ++
 rtl/snake_bitmap.sv | 37 +++
 rtl/snake_grid_reader.sv | 207 ++++++++++++++++++++
 tb/tb_snake_grid_reader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared constants, FSM state type and cell codes for the snake grid reader.
// Optional self-hit detection is enabled by defining SNAKE_SELF_HIT_EN.
package snake_pkg;

    localparam int unsigned GRID_W   = 16;
    localparam int unsigned NUM_SEGS = 225;
    localparam int unsigned SEG_W    = 8;
    localparam int unsigned SNAKE_W  = NUM_SEGS * SEG_W;
    localparam int unsigned CELLS    = GRID_W * GRID_W;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StScan,
        StPublish
    } state_e;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BODY  = 2'b01;
    localparam logic [1:0] CELL_HEAD  = 2'b10;

    // Single-bit read of a flattened bitmap; cell (y,x) lives at bit {y,x}.
    function automatic logic cell_bit(input logic [CELLS-1:0] bits,
                                      input logic [3:0] y,
                                      input logic [3:0] x);
        return bits[{y, x}];
    endfunction

endpackage

// File: rtl/snake_bitmap.sv
// 16x16 occupancy bitmap with row clear, single-bit set and whole-array copy.
// Reads are done on the flattened bits output with snake_pkg::cell_bit.
module snake_bitmap
    import snake_pkg::*;
(
    input  logic             slw_clk,
    input  logic             reset_n,
    input  logic             clr_en,
    input  logic [3:0]       clr_row,
    input  logic             set_en,
    input  logic [3:0]       set_y,
    input  logic [3:0]       set_x,
    input  logic             copy_en,
    input  logic [CELLS-1:0] copy_src,
    output logic [CELLS-1:0] bits
);

    logic [CELLS-1:0] bits_q;

    always_ff @(posedge slw_clk or negedge reset_n) begin
        if (!reset_n) begin
            bits_q <= '0;
        end else if (copy_en) begin
            bits_q <= copy_src;
        end else begin
            if (clr_en) begin
                bits_q[{clr_row, 4'h0} +: GRID_W] <= '0;
            end
            if (set_en) begin
                bits_q[{set_y, set_x}] <= 1'b1;
            end
        end
    end

    assign bits = bits_q;

endmodule

// File: rtl/snake_grid_reader.sv
// Captures the packed snake body, rasterises it into a work bitmap and publishes
// it double-buffered to a queryable display bitmap. SNAKE_SELF_HIT_EN adds self-hit.
module snake_grid_reader
    import snake_pkg::*;
(
    input  logic               slw_clk,
    input  logic               reset_n,
    input  logic [SNAKE_W-1:0] snake,
    input  logic               write_snake,
    input  logic [3:0]         rd_y,
    input  logic [3:0]         rd_x,
    output logic [1:0]         rd_cell,
    output logic [7:0]         length,
    output logic [3:0]         head_y,
    output logic [3:0]         head_x,
    output logic               busy,
    output logic               frame_done,
    output logic               self_hit
);

    state_e             state_q, state_d;
    logic [SNAKE_W-1:0] shadow_q, shadow_d;
    logic [3:0]         row_q, row_d;
    logic [7:0]         k_q, k_d;
    logic [7:0]         count_q, count_d;
    logic [3:0]         hw_y_q, hw_y_d;
    logic [3:0]         hw_x_q, hw_x_d;

    logic               clr_en, set_en, copy_en, publish;
    logic [SEG_W-1:0]   seg;
    logic [CELLS-1:0]   work_bits, disp_bits;

    logic [1:0]         rd_cell_q;
    logic [7:0]         length_q;
    logic [3:0]         head_y_q, head_x_q;
    logic               frame_done_q;

`ifdef SNAKE_SELF_HIT_EN
    logic               hit_q, hit_d;
    logic               self_hit_q;
`endif

    assign seg = shadow_q[{k_q, 3'b000} +: SEG_W];

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        row_d    = row_q;
        k_d      = k_q;
        count_d  = count_q;
        hw_y_d   = hw_y_q;
        hw_x_d   = hw_x_q;
`ifdef SNAKE_SELF_HIT_EN
        hit_d    = hit_q;
`endif
        clr_en   = 1'b0;
        set_en   = 1'b0;
        copy_en  = 1'b0;
        publish  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (write_snake) begin
                    shadow_d = snake;
                    row_d    = 4'd0;
                    state_d  = StClear;
                end
            end
            StClear: begin
                clr_en = 1'b1;
                row_d  = row_q + 4'd1;
                if (row_q == 4'(GRID_W - 1)) begin
                    k_d     = 8'd0;
                    count_d = 8'd0;
`ifdef SNAKE_SELF_HIT_EN
                    hit_d   = 1'b0;
`endif
                    state_d = StScan;
                end
            end
            StScan: begin
                if (seg != '0) begin
                    set_en  = 1'b1;
                    count_d = count_q + 8'd1;
                    hw_y_d  = seg[7:4];
                    hw_x_d  = seg[3:0];
`ifdef SNAKE_SELF_HIT_EN
                    // Read-before-set: work bit still holds its pre-edge value here.
                    hit_d   = hit_q | cell_bit(work_bits, seg[7:4], seg[3:0]);
`endif
                end
                if (seg == '0 || k_q == 8'(NUM_SEGS - 1)) begin
                    state_d = StPublish;
                end else begin
                    k_d = k_q + 8'd1;
                end
            end
            StPublish: begin
                copy_en = 1'b1;
                publish = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge slw_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            shadow_q <= '0;
            row_q    <= '0;
            k_q      <= '0;
            count_q  <= '0;
            hw_y_q   <= '0;
            hw_x_q   <= '0;
`ifdef SNAKE_SELF_HIT_EN
            hit_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            row_q    <= row_d;
            k_q      <= k_d;
            count_q  <= count_d;
            hw_y_q   <= hw_y_d;
            hw_x_q   <= hw_x_d;
`ifdef SNAKE_SELF_HIT_EN
            hit_q    <= hit_d;
`endif
        end
    end

    snake_bitmap u_work (
        .slw_clk  (slw_clk),
        .reset_n  (reset_n),
        .clr_en   (clr_en),
        .clr_row  (row_q),
        .set_en   (set_en),
        .set_y    (seg[7:4]),
        .set_x    (seg[3:0]),
        .copy_en  (1'b0),
        .copy_src ('0),
        .bits     (work_bits)
    );

    snake_bitmap u_disp (
        .slw_clk  (slw_clk),
        .reset_n  (reset_n),
        .clr_en   (1'b0),
        .clr_row  (4'd0),
        .set_en   (1'b0),
        .set_y    (4'd0),
        .set_x    (4'd0),
        .copy_en  (copy_en),
        .copy_src (work_bits),
        .bits     (disp_bits)
    );

    // Published outputs and the query register; all update on the PUBLISH edge,
    // so a query sampled on that edge still sees the previous frame.
    always_ff @(posedge slw_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cell_q    <= CELL_EMPTY;
            length_q     <= '0;
            head_y_q     <= '0;
            head_x_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= publish;
            if (publish) begin
                length_q <= count_q;
                if (count_q != 8'd0) begin
                    head_y_q <= hw_y_q;
                    head_x_q <= hw_x_q;
                end
            end
            if (length_q != 8'd0 && rd_y == head_y_q && rd_x == head_x_q) begin
                rd_cell_q <= CELL_HEAD;
            end else if (cell_bit(disp_bits, rd_y, rd_x)) begin
                rd_cell_q <= CELL_BODY;
            end else begin
                rd_cell_q <= CELL_EMPTY;
            end
        end
    end

`ifdef SNAKE_SELF_HIT_EN
    always_ff @(posedge slw_clk or negedge reset_n) begin
        if (!reset_n) begin
            self_hit_q <= 1'b0;
        end else if (publish) begin
            self_hit_q <= hit_q;
        end
    end
    assign self_hit = self_hit_q;
`else
    assign self_hit = 1'b0;
`endif

    assign rd_cell    = rd_cell_q;
    assign length     = length_q;
    assign head_y     = head_y_q;
    assign head_x     = head_x_q;
    assign busy       = (state_q != StIdle);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_snake_grid_reader.sv
// Directed self-checking bench for snake_grid_reader (honours SNAKE_SELF_HIT_EN).
module tb_snake_grid_reader;

    logic          slw_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1799:0] snake = '0;
    logic          write_snake = 1'b0;
    logic [3:0]    rd_y = '0;
    logic [3:0]    rd_x = '0;
    logic [1:0]    rd_cell;
    logic [7:0]    length;
    logic [3:0]    head_y, head_x;
    logic          busy, frame_done, self_hit;

    int passed = 0;
    int total  = 0;

    always #5 slw_clk = ~slw_clk;

    snake_grid_reader dut (
        .slw_clk     (slw_clk),
        .reset_n     (reset_n),
        .snake       (snake),
        .write_snake (write_snake),
        .rd_y        (rd_y),
        .rd_x        (rd_x),
        .rd_cell     (rd_cell),
        .length      (length),
        .head_y      (head_y),
        .head_x      (head_x),
        .busy        (busy),
        .frame_done  (frame_done),
        .self_hit    (self_hit)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Pulse write_snake for one capture edge, then count edges until frame_done.
    task automatic run_frame(input logic [1799:0] vec, output int edges);
        @(negedge slw_clk);
        snake = vec;
        write_snake = 1'b1;
        @(posedge slw_clk);
        #1;
        write_snake = 1'b0;
        edges = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge slw_clk);
            #1;
            if (frame_done) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic query(input string tag, input logic [3:0] y, input logic [3:0] x,
                         input logic [1:0] exp);
        @(negedge slw_clk);
        rd_y = y;
        rd_x = x;
        @(posedge slw_clk);
        #1;
        chk(tag, rd_cell, exp);
    endtask

    initial begin
        logic [1799:0] v;
        logic [1799:0] vb;
        int            edges;
        int            pulses;
        logic          exp_hit;

`ifdef SNAKE_SELF_HIT_EN
        exp_hit = 1'b1;
`else
        exp_hit = 1'b0;
`endif

        // Reset values
        #12;
        chk("rst_rd_cell", rd_cell, 2'b00);
        chk("rst_length", length, 8'd0);
        chk("rst_head", {head_y, head_x}, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_self_hit", self_hit, 1'b0);
        @(negedge slw_clk);
        reset_n = 1'b1;

        // Three-segment snake
        v = '0;
        v[7:0] = 8'h11;
        v[15:8] = 8'h12;
        v[23:16] = 8'h13;
        run_frame(v, edges);
        chk("l3_latency", edges, 21);
        chk("l3_length", length, 8'd3);
        chk("l3_head", {head_y, head_x}, 8'h13);
        chk("l3_busy_low", busy, 1'b0);
        chk("l3_self_hit", self_hit, 1'b0);
        query("q_1_2", 4'd1, 4'd2, 2'b01);
        query("q_1_3", 4'd1, 4'd3, 2'b10);
        query("q_1_1", 4'd1, 4'd1, 2'b01);
        query("q_5_5", 4'd5, 4'd5, 2'b00);

        // Empty frame: head keeps previous value
        run_frame('0, edges);
        chk("l0_latency", edges, 18);
        chk("l0_length", length, 8'd0);
        chk("l0_head_kept", {head_y, head_x}, 8'h13);
        query("l0_q_1_3", 4'd1, 4'd3, 2'b00);
        query("l0_q_1_2", 4'd1, 4'd2, 2'b00);

        // Full 225-segment snake, all cells distinct; last segment 0xE1
        v = '0;
        for (int k = 0; k < 225; k++) v[k*8 +: 8] = 8'(k + 1);
        run_frame(v, edges);
        chk("l225_latency", edges, 242);
        chk("l225_length", length, 8'd225);
        chk("l225_head", {head_y, head_x}, 8'hE1);
        chk("l225_self_hit", self_hit, 1'b0);
        query("l225_q_e0", 4'd14, 4'd0, 2'b01);
        query("l225_q_f0", 4'd15, 4'd0, 2'b00);

        // Self hit: 0x11 visited twice, head back at (1,1)
        v = '0;
        v[7:0] = 8'h11;
        v[15:8] = 8'h12;
        v[23:16] = 8'h11;
        run_frame(v, edges);
        chk("sh_latency", edges, 21);
        chk("sh_length", length, 8'd3);
        chk("sh_self_hit", self_hit, exp_hit);
        query("sh_q_1_1", 4'd1, 4'd1, 2'b10);
        query("sh_q_1_2", 4'd1, 4'd2, 2'b01);

        // Held write_snake with vector changed mid-SCAN
        v = '0;
        v[7:0] = 8'h21;
        v[15:8] = 8'h22;
        vb = '0;
        vb[7:0] = 8'h33;
        @(negedge slw_clk);
        snake = v;
        write_snake = 1'b1;
        @(posedge slw_clk);
        #1;
        for (int i = 1; i <= 18; i++) @(posedge slw_clk);
        #1;
        snake = vb;
        edges = -1;
        for (int i = 19; i <= 300; i++) begin
            @(posedge slw_clk);
            #1;
            if (frame_done) begin
                edges = i;
                break;
            end
        end
        chk("hold_latency", edges, 20);
        chk("hold_length_old", length, 8'd2);
        chk("hold_head_old", {head_y, head_x}, 8'h22);
        @(posedge slw_clk);
        #1;
        write_snake = 1'b0;
        chk("hold_recapture_busy", busy, 1'b1);
        edges = -1;
        for (int i = 2; i <= 300; i++) begin
            @(posedge slw_clk);
            #1;
            if (frame_done) begin
                edges = i;
                break;
            end
        end
        chk("hold_second_latency", edges, 20);
        chk("hold_length_new", length, 8'd1);
        chk("hold_head_new", {head_y, head_x}, 8'h33);

        // Reset during SCAN: no publish, everything back to reset values
        v = '0;
        v[7:0] = 8'h41;
        v[15:8] = 8'h42;
        v[23:16] = 8'h43;
        v[31:24] = 8'h44;
        @(negedge slw_clk);
        rd_y = 4'd3;
        rd_x = 4'd3;
        snake = v;
        write_snake = 1'b1;
        @(posedge slw_clk);
        #1;
        write_snake = 1'b0;
        for (int i = 1; i <= 18; i++) @(posedge slw_clk);
        @(negedge slw_clk);
        chk("pre_rst_rd_cell", rd_cell, 2'b10);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_length", length, 8'd0);
        chk("mid_rst_head", {head_y, head_x}, 8'h00);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rd_cell", rd_cell, 2'b00);
        chk("mid_rst_frame_done", frame_done, 1'b0);
        chk("mid_rst_self_hit", self_hit, 1'b0);
        @(negedge slw_clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge slw_clk);
            #1;
            if (frame_done) pulses++;
        end
        chk("mid_rst_no_pulse", pulses, 0);
        chk("mid_rst_idle", busy, 1'b0);
        query("mid_rst_q_4_1", 4'd4, 4'd1, 2'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
